// File: rtl/pc_fetch_unit.sv
// PC register, single-outstanding fetch FSM and one-entry instruction slot.
// Redirects arriving mid-fetch are parked and replayed when the ack lands.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    input  logic        JumpTaken,
    input  logic [31:0] JumpTarget,
    output logic [31:0] PCResult,
    input  logic [31:0] PCAddResult,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    input  logic        IMemAck,
    input  logic [31:0] IMemData,
    output logic        InstrValid,
    output logic [31:0] Instruction,
    output logic [31:0] InstrPC
);

    typedef enum logic {IDLE, REQ} state_t;

    state_t      state;
    state_t      state_nxt;
    logic        redirect;
    logic [31:0] target;
    logic        consume;
    logic        pend_valid;
    logic [31:0] pend_target;

    assign redirect = JumpTaken | BranchTaken;
    assign target   = JumpTaken ? JumpTarget : BranchTarget;
    assign consume  = InstrValid & ~Stall;
    assign IMemAddr = PCResult;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        IMemReq   = 1'b0;
        unique case (state)
            IDLE: begin
                if (!InstrValid || !Stall) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                IMemReq = 1'b1;
                // a discarded response immediately re-issues at the new PC
                if (IMemAck && !redirect && !pend_valid) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            PCResult    <= RESET_PC;
            InstrValid  <= 1'b0;
            Instruction <= 32'h0;
            InstrPC     <= 32'h0;
            pend_valid  <= 1'b0;
            pend_target <= 32'h0;
        end else if (state == IDLE) begin
            if (redirect) begin
                PCResult <= target;
            end
            if (redirect || consume) begin
                InstrValid <= 1'b0;
            end
        end else if (IMemAck) begin
            pend_valid <= 1'b0;
            if (redirect) begin
                PCResult   <= target;
                InstrValid <= 1'b0;
            end else if (pend_valid) begin
                PCResult <= pend_target;
                if (consume) begin
                    InstrValid <= 1'b0;
                end
            end else begin
                Instruction <= IMemData;
                InstrPC     <= PCResult;
                InstrValid  <= 1'b1;
                PCResult    <= PCAddResult;
            end
        end else if (redirect) begin
            // PC must hold while the fetch is in flight
            pend_valid  <= 1'b1;
            pend_target <= target;
            InstrValid  <= 1'b0;
        end else if (consume) begin
            InstrValid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios plus randomized traffic
// checked against a transaction-level fetch model.
module tb_pc_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0400;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Stall;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic        JumpTaken;
    logic [31:0] JumpTarget;
    logic [31:0] PCResult;
    logic [31:0] PCAddResult;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic        IMemAck;
    logic [31:0] IMemData;
    logic        InstrValid;
    logic [31:0] Instruction;
    logic [31:0] InstrPC;

    int vectors = 0;
    int errors  = 0;

    // behavioural model state
    logic [31:0] m_pc;
    logic        m_busy;
    logic        m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_ipc;
    logic        m_pend;
    logic [31:0] m_ptgt;

    always #5 Clk = ~Clk;

    assign PCAddResult = PCResult + 32'd4;

    pc_fetch_unit #(.RESET_PC(RST_PC)) dut (
        .Clk(Clk),
        .Reset(Reset),
        .Stall(Stall),
        .BranchTaken(BranchTaken),
        .BranchTarget(BranchTarget),
        .JumpTaken(JumpTaken),
        .JumpTarget(JumpTarget),
        .PCResult(PCResult),
        .PCAddResult(PCAddResult),
        .IMemReq(IMemReq),
        .IMemAddr(IMemAddr),
        .IMemAck(IMemAck),
        .IMemData(IMemData),
        .InstrValid(InstrValid),
        .Instruction(Instruction),
        .InstrPC(InstrPC)
    );

    task automatic model_reset();
        m_pc    = RST_PC;
        m_busy  = 1'b0;
        m_valid = 1'b0;
        m_instr = 32'h0;
        m_ipc   = 32'h0;
        m_pend  = 1'b0;
        m_ptgt  = 32'h0;
    endtask

    task automatic idle_inputs();
        Stall = 0; BranchTaken = 0; BranchTarget = 0;
        JumpTaken = 0; JumpTarget = 0; IMemAck = 0; IMemData = 0;
    endtask

    // apply one cycle of inputs from a negedge, advance the model at the edge
    task automatic cycle(input logic st, input logic bt,
                         input logic [31:0] btg, input logic jt,
                         input logic [31:0] jtg, input logic ack,
                         input logic [31:0] dat);
        logic        redir;
        logic [31:0] tgt;
        logic        take;
        logic        start;
        Stall = st; BranchTaken = bt; BranchTarget = btg;
        JumpTaken = jt; JumpTarget = jtg; IMemAck = ack; IMemData = dat;
        @(posedge Clk);
        redir = jt | bt;
        tgt   = jt ? jtg : btg;
        take  = m_valid && !st;
        if (!m_busy) begin
            start = !m_valid || !st;
            if (redir) m_pc = tgt;
            if (redir || take) m_valid = 0;
            m_busy = start;
        end else if (ack) begin
            if (redir) begin
                m_pc = tgt; m_pend = 0; m_valid = 0;
            end else if (m_pend) begin
                m_pc = m_ptgt; m_pend = 0;
                if (take) m_valid = 0;
            end else begin
                m_instr = dat; m_ipc = m_pc; m_valid = 1;
                m_pc = m_pc + 32'd4; m_busy = 0;
            end
        end else if (redir) begin
            m_pend = 1; m_ptgt = tgt; m_valid = 0;
        end else if (take) begin
            m_valid = 0;
        end
        @(negedge Clk);
    endtask

    task automatic test_reset();
        idle_inputs();
        Reset = 1'b1;
        #1;
        model_reset();
        vectors++; if (PCResult !== RST_PC) begin errors++;
            $display("FAIL rst_pc got %h exp %h", PCResult, RST_PC); end
        vectors++; if (IMemReq !== 1'b0) begin errors++;
            $display("FAIL rst_req got %b exp 0", IMemReq); end
        vectors++; if (InstrValid !== 1'b0) begin errors++;
            $display("FAIL rst_valid got %b exp 0", InstrValid); end
        vectors++; if (Instruction !== 32'h0) begin errors++;
            $display("FAIL rst_instr got %h exp 0", Instruction); end
        vectors++; if (InstrPC !== 32'h0) begin errors++;
            $display("FAIL rst_ipc got %h exp 0", InstrPC); end
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    task automatic test_sequential();
        logic [31:0] d;
        cycle(0, 0, 0, 0, 0, 0, 0);
        vectors++; if (IMemReq !== 1'b1 || IMemAddr !== RST_PC) begin errors++;
            $display("FAIL seq_first got %b/%h exp 1/%h", IMemReq, IMemAddr, RST_PC); end
        for (int k = 0; k < 3; k++) begin
            d = $urandom;
            cycle(0, 0, 0, 0, 0, 1, d);
            vectors++; if (InstrValid !== 1'b1 || Instruction !== d) begin errors++;
                $display("FAIL seq_instr got %b/%h exp 1/%h", InstrValid, Instruction, d); end
            vectors++; if (InstrPC !== RST_PC + 32'(4 * k) || IMemReq !== 1'b0) begin errors++;
                $display("FAIL seq_ipc got %h/%b exp %h/0", InstrPC, IMemReq, RST_PC + 32'(4 * k)); end
            cycle(0, 0, 0, 0, 0, 0, 0);
            vectors++; if (IMemReq !== 1'b1 || IMemAddr !== RST_PC + 32'(4 * (k + 1))) begin errors++;
                $display("FAIL seq_next got %b/%h exp 1/%h", IMemReq, IMemAddr, RST_PC + 32'(4 * (k + 1))); end
        end
    endtask

    task automatic test_stall();
        logic [31:0] d;
        d = $urandom;
        cycle(0, 0, 0, 0, 0, 1, d);
        for (int k = 0; k < 3; k++) begin
            cycle(1, 0, 0, 0, 0, 0, 0);
            vectors++; if (IMemReq !== 1'b0 || InstrValid !== 1'b1) begin errors++;
                $display("FAIL stall_req got %b/%b exp 0/1", IMemReq, InstrValid); end
            vectors++; if (Instruction !== d || InstrPC !== 32'h40C) begin errors++;
                $display("FAIL stall_hold got %h/%h exp %h/0000040c", Instruction, InstrPC, d); end
        end
        cycle(0, 0, 0, 0, 0, 0, 0);
        vectors++; if (IMemReq !== 1'b1 || IMemAddr !== 32'h410) begin errors++;
            $display("FAIL stall_release got %b/%h exp 1/00000410", IMemReq, IMemAddr); end
    endtask

    task automatic test_branch_pending();
        logic [31:0] d;
        cycle(0, 1, 32'h100, 0, 0, 0, 0);
        vectors++; if (IMemAddr !== 32'h410 || IMemReq !== 1'b1) begin errors++;
            $display("FAIL br_hold got %h/%b exp 00000410/1", IMemAddr, IMemReq); end
        cycle(0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF);
        vectors++; if (IMemAddr !== 32'h100 || IMemReq !== 1'b1 || InstrValid !== 1'b0) begin errors++;
            $display("FAIL br_redirect got %h/%b/%b exp 00000100/1/0", IMemAddr, IMemReq, InstrValid); end
        d = $urandom;
        cycle(0, 0, 0, 0, 0, 1, d);
        vectors++; if (InstrPC !== 32'h100 || Instruction !== d || InstrValid !== 1'b1) begin errors++;
            $display("FAIL br_fetch got %h/%h exp 00000100/%h", InstrPC, Instruction, d); end
        cycle(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_jump_priority();
        logic [31:0] d;
        cycle(0, 1, 32'h300, 1, 32'h200, 1, 32'hBAD0_BAD0);
        vectors++; if (PCResult !== 32'h200 || IMemReq !== 1'b1 || InstrValid !== 1'b0) begin errors++;
            $display("FAIL jmp_prio got %h/%b/%b exp 00000200/1/0", PCResult, IMemReq, InstrValid); end
        d = $urandom;
        cycle(0, 0, 0, 0, 0, 1, d);
        vectors++; if (InstrPC !== 32'h200 || Instruction !== d) begin errors++;
            $display("FAIL jmp_fetch got %h/%h exp 00000200/%h", InstrPC, Instruction, d); end
    endtask

    task automatic test_redirect_idle();
        cycle(0, 1, 32'h40, 0, 0, 0, 0);
        vectors++; if (InstrValid !== 1'b0 || IMemAddr !== 32'h40 || IMemReq !== 1'b1) begin errors++;
            $display("FAIL idle_redir got %b/%h/%b exp 0/00000040/1", InstrValid, IMemAddr, IMemReq); end
        cycle(0, 0, 0, 0, 0, 1, 32'h1234_5678);
        vectors++; if (InstrPC !== 32'h40 || Instruction !== 32'h1234_5678) begin errors++;
            $display("FAIL idle_fetch got %h/%h exp 00000040/12345678", InstrPC, Instruction); end
    endtask

    task automatic test_wrap();
        cycle(0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0);
        cycle(0, 0, 0, 0, 0, 1, 32'hCAFE_F00D);
        vectors++; if (InstrPC !== 32'hFFFF_FFFC || PCResult !== 32'h0) begin errors++;
            $display("FAIL wrap got %h/%h exp fffffffc/00000000", InstrPC, PCResult); end
    endtask

    task automatic test_reset_midfetch();
        cycle(0, 0, 0, 0, 0, 0, 0);
        #2;
        Reset = 1'b1;
        #1;
        model_reset();
        vectors++; if (IMemReq !== 1'b0 || InstrValid !== 1'b0 || PCResult !== RST_PC) begin errors++;
            $display("FAIL mid_rst got %b/%b/%h exp 0/0/%h", IMemReq, InstrValid, PCResult, RST_PC); end
        vectors++; if (Instruction !== 32'h0 || InstrPC !== 32'h0) begin errors++;
            $display("FAIL mid_rst_slot got %h/%h exp 0/0", Instruction, InstrPC); end
        @(negedge Clk);
        Reset = 1'b0;
        cycle(0, 0, 0, 0, 0, 1, 32'h5555_AAAA);
        vectors++; if (IMemReq !== 1'b1 || IMemAddr !== RST_PC || InstrValid !== 1'b0) begin errors++;
            $display("FAIL mid_release got %b/%h/%b exp 1/%h/0", IMemReq, IMemAddr, InstrValid, RST_PC); end
    endtask

    task automatic test_random();
        logic        st, bt, jt, ack;
        logic [31:0] btg, jtg, dat;
        for (int n = 0; n < 400; n++) begin
            st  = ($urandom_range(0, 9) < 3);
            bt  = ($urandom_range(0, 9) == 0);
            jt  = ($urandom_range(0, 9) == 0);
            ack = ($urandom_range(0, 9) < 4);
            btg = $urandom & 32'hFFFF_FFFC;
            jtg = $urandom & 32'hFFFF_FFFC;
            dat = $urandom;
            cycle(st, bt, btg, jt, jtg, ack, dat);
            vectors++; if (IMemReq !== m_busy || IMemAddr !== m_pc || PCResult !== m_pc) begin errors++;
                $display("FAIL rnd_fetch n=%0d got %b/%h/%h exp %b/%h", n, IMemReq, IMemAddr, PCResult, m_busy, m_pc); end
            vectors++; if (InstrValid !== m_valid || Instruction !== m_instr || InstrPC !== m_ipc) begin errors++;
                $display("FAIL rnd_slot n=%0d got %b/%h/%h exp %b/%h/%h", n, InstrValid, Instruction, InstrPC, m_valid, m_instr, m_ipc); end
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_branch_pending();
        test_jump_priority();
        test_redirect_idle();
        test_wrap();
        test_reset_midfetch();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, the PC value loaded on reset.
REQ-002 Clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 Reset  input  1  asynchronous, active-high reset.
REQ-004 Stall  input  1  decode cannot accept the held instruction this cycle.
REQ-005 BranchTaken  input  1  single-cycle redirect pulse; BranchTarget  input  32  its target.
REQ-006 JumpTaken  input  1  single-cycle redirect pulse; JumpTarget  input  32  its target.
REQ-007 PCResult  output  32  current PC register, which drives the external PC+4 adder.
REQ-008 PCAddResult  input  32  the external adder's result, PCResult + 4.
REQ-009 IMemReq  output  1  fetch request; IMemAddr  output  32  the fetch address, equal to PCResult.
REQ-010 IMemAck  input  1  fetch complete; IMemData  input  32  the fetched word, valid with IMemAck.
REQ-011 InstrValid  output  1  the output slot holds an instruction.
REQ-012 Instruction  output  32  the held instruction; InstrPC  output  32  its fetch address.

Function
REQ-013 The FSM SHALL have two states: IDLE (no fetch outstanding) and REQ (IMemReq=1, one fetch outstanding); IMemReq SHALL be decoded from state only.
REQ-014 The slot SHALL be consumed at an edge where InstrValid=1 and Stall=0, and InstrValid SHALL then clear unless refilled that edge.
REQ-015 IDLE->REQ SHALL occur at an edge where InstrValid=0, or where InstrValid=1 and Stall=0; otherwise the FSM SHALL stay in IDLE.
REQ-016 While in REQ, PCResult and IMemAddr SHALL stay stable until the edge that samples IMemAck=1.
REQ-017 Redirect target SHALL be JumpTarget when JumpTaken=1, otherwise BranchTarget when BranchTaken=1, so jump has priority.
REQ-018 Any redirect edge SHALL clear InstrValid, squashing the younger held instruction.
REQ-019 Redirect in IDLE: PCResult<=target at that edge, and the FSM SHALL follow REQ-015.
REQ-020 Redirect in REQ without IMemAck: PendValid<=1 and PendTarget<=target; a later redirect SHALL overwrite PendTarget.
REQ-021 IMemAck in REQ with a redirect at the same edge: IMemData SHALL be discarded, PCResult<=target, PendValid<=0, and the next state SHALL be REQ.
REQ-022 IMemAck in REQ with PendValid=1 and no redirect: IMemData SHALL be discarded, PCResult<=PendTarget, PendValid<=0, and the next state SHALL be REQ.
REQ-023 IMemAck in REQ, clean case: Instruction<=IMemData, InstrPC<=PCResult, InstrValid<=1, PCResult<=PCAddResult, and the next state SHALL be IDLE.
REQ-024 IMemAck sampled while in IDLE SHALL be ignored.
REQ-025 Stall SHALL NOT affect an outstanding fetch; it gates only REQ-014 and REQ-015.
REQ-026 PC arithmetic SHALL be external; PCAddResult SHALL be used unmodified, and wrap from 32'hFFFF_FFFC to 32'h0000_0000 is the adder's result.
REQ-027 Held Instruction and InstrPC SHALL stay stable while InstrValid=1 and Stall=1.

Reset
REQ-028 Reset=1 SHALL immediately force PCResult=RESET_PC, state=IDLE, IMemReq=0, InstrValid=0, Instruction=0, InstrPC=0, PendValid=0 and PendTarget=0, without waiting for Clk.
REQ-029 Reset asserted mid-fetch SHALL abandon the fetch, and an IMemAck arriving after Reset deasserts SHALL be ignored unless the FSM is in REQ.
REQ-030 On the first edge after Reset deasserts, the FSM SHALL enter REQ with IMemAddr=RESET_PC.

Verification
REQ-031 Reset release, ack 1 cycle after each req, Stall=0 -> IMemAddr 0x0, 0x4, 0x8; Instruction/InstrPC pairs match; one instruction per 2 cycles.
REQ-032 Stall=1 for 3 cycles while InstrValid=1 (InstrPC=0x4) -> no new IMemReq, outputs stable; request for 0x8 one edge after Stall falls.
REQ-033 BranchTaken=1, BranchTarget=0x100 during an outstanding fetch of 0x8, ack 2 cycles later -> 0x8 data discarded, next IMemAddr=0x100, next InstrPC=0x100.
REQ-034 JumpTaken=1 (0x200) with BranchTaken=1 (0x300) in the same cycle as IMemAck -> data discarded, PCResult=0x200.
REQ-035 Redirect to 0x40 in IDLE with InstrValid=1 -> InstrValid clears that edge; next fetch address is 0x40.
REQ-036 Reset pulsed mid-fetch at PC=0xC with RESET_PC=0x400 -> outputs zero immediately, PCResult=0x400, first fetch after release is 0x400.
